// File: rtl/ecg_enc_pkg.sv
// Shared constants, types and helpers for the multi-channel ECG spike encoder.
// Q4.16 signed fixed point at the default width. Provides the threshold and reset constants,
// the FSM state type, and a saturating narrow-down helper for W+3 bit intermediates.
package ecg_enc_pkg;

  localparam int W    = 20;
  localparam int FRAC = 16;

  localparam logic signed [W-1:0] ONE  = 20'sh1_0000;  //  1.0
  localparam logic signed [W-1:0] VTH  = 20'sh1_0000;  //  1.0 firing threshold
  localparam logic signed [W-1:0] VRST = 20'shF_0000;  // -1.0 post-spike V
  localparam logic signed [W-1:0] UJMP = 20'sh0_2000;  //  0.125 post-spike U kick

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Clamp a W+3 bit value into W bits. Overflow shows up as the top guard bits
  // disagreeing with the W-bit sign bit.
  function automatic logic signed [W-1:0] sat_w(input logic signed [W+2:0] a);
    if (a[W+2] && !(&a[W+1:W-1]))
      return {1'b1, {(W-1){1'b0}}};
    else if (!a[W+2] && (|a[W+1:W-1]))
      return {1'b0, {(W-1){1'b1}}};
    else
      return a[W-1:0];
  endfunction

endpackage

// File: rtl/ecg_spike_encoder_mc_vu_neuron_step.sv
// Combinational single-channel V/U neuron update, shared by all channels of the encoder.
// Ports: v/u current state, i_c channel current, p bias -> v_next/u_next/spike.
// All arithmetic is done W+3 bits wide and saturated back to W.
module vu_neuron_step #(
  parameter int                  W     = 20,
  parameter logic signed [W-1:0] VTH   = 20'sh1_0000,
  parameter logic signed [W-1:0] VRST  = 20'shF_0000,
  parameter logic signed [W-1:0] UJMP  = 20'sh0_2000,
  parameter int                  TV_SH = 2,
  parameter int                  TU_SH = 4
) (
  input  logic signed [W-1:0] v,
  input  logic signed [W-1:0] u,
  input  logic signed [W-1:0] i_c,
  input  logic signed [W-1:0] p,
  output logic signed [W-1:0] v_next,
  output logic signed [W-1:0] u_next,
  output logic                spike
);

  localparam int WE = W + 3;

  function automatic logic signed [WE-1:0] sx(input logic signed [W-1:0] a);
    return {{3{a[W-1]}}, a};
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [WE-1:0] a);
    if (a[WE-1] && !(&a[WE-2:W-1]))
      return {1'b1, {(W-1){1'b0}}};
    else if (!a[WE-1] && (|a[WE-2:W-1]))
      return {1'b0, {(W-1){1'b1}}};
    else
      return a[W-1:0];
  endfunction

  logic signed [WE-1:0] d, v_sum, u_sum, u_kick;
  logic signed [W-1:0]  v_sat, u_sat;

  always_comb begin
    d      = sx(i_c) + sx(p) - sx(u) - sx(v);
    v_sum  = sx(v) + (d >>> TV_SH);
    // Adaptation uses the pre-update v.
    u_sum  = sx(u) + ((sx(v) - sx(u)) >>> TU_SH);
    v_sat  = sat(v_sum);
    u_sat  = sat(u_sum);
    spike  = (v_sat >= VTH);
    u_kick = sx(u_sat) + sx(UJMP);
    v_next = spike ? VRST : v_sat;
    u_next = spike ? sat(u_kick) : u_sat;
  end

endmodule

// File: rtl/ecg_spike_encoder_mc.sv
// Time-multiplexed NCH-channel spike encoder: one shared neuron step, per-channel V/U arrays.
// Ports: sample in (s_data/s_valid/s_ready), spike vector out (o_spk/o_any/o_valid),
// saturating spike count, clear, and a registered V/U monitor selected by mon_sel.
module ecg_spike_encoder_mc #(
  parameter int                  W     = ecg_enc_pkg::W,
  parameter int                  NCH   = 2,
  parameter logic signed [W-1:0] VTH   = ecg_enc_pkg::VTH,
  parameter logic signed [W-1:0] VRST  = ecg_enc_pkg::VRST,
  parameter logic signed [W-1:0] UJMP  = ecg_enc_pkg::UJMP,
  parameter int                  TV_SH = 2,
  parameter int                  TU_SH = 4,
  parameter int                  CW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic signed [W-1:0] p,
  input  logic signed [W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [NCH-1:0]      o_spk,
  output logic                o_any,
  output logic                o_valid,
  output logic [CW-1:0]       spk_cnt,
  input  logic [3:0]          mon_sel,
  output logic signed [W-1:0] mon_v,
  output logic signed [W-1:0] mon_u
);
  import ecg_enc_pkg::*;

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t               state, state_nx;
  logic [CHW-1:0]       ch;
  logic signed [W-1:0]  x_q;
  logic signed [W-1:0]  v_arr [NCH];
  logic signed [W-1:0]  u_arr [NCH];
  logic [NCH-1:0]       spk_acc, spk_new;
  logic                 rst_done;
  logic                 last_ch;

  logic signed [W-1:0]  x_sel, i_cur, v_nx, u_nx;
  logic                 spike;
  logic [CW:0]          pc, cnt_sum;
  logic [CW-1:0]        cnt_nx;

  // Odd channels see the inverted sample; channel pairs step down one octave each.
  always_comb begin
    x_sel = ch[0] ? ~x_q : x_q;
    i_cur = x_sel >>> (ch >> 1);
  end

  vu_neuron_step #(
    .W(W), .VTH(VTH), .VRST(VRST), .UJMP(UJMP), .TV_SH(TV_SH), .TU_SH(TU_SH)
  ) u_step (
    .v(v_arr[ch]), .u(u_arr[ch]), .i_c(i_cur), .p(p),
    .v_next(v_nx), .u_next(u_nx), .spike(spike)
  );

  assign last_ch = (ch == CHW'(NCH - 1));

  // Completed spike vector including the channel being written this cycle.
  always_comb begin
    spk_new     = spk_acc;
    spk_new[ch] = spike;
    pc          = '0;
    for (int i = 0; i < NCH; i++)
      pc = pc + (CW+1)'(spk_new[i]);
    cnt_sum = {1'b0, spk_cnt} + pc;
    cnt_nx  = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
  end

  // s_ready stays low until the first clock after reset release.
  assign s_ready = rst_done && (state == IDLE);
  assign o_any   = |o_spk;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (s_valid && s_ready) state_nx = RUN;
      RUN:     if (last_ch) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clear) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ch       <= '0;
      x_q      <= '0;
      spk_acc  <= '0;
      o_spk    <= '0;
      o_valid  <= 1'b0;
      spk_cnt  <= '0;
      rst_done <= 1'b0;
      mon_v    <= '0;
      mon_u    <= '0;
      for (int i = 0; i < NCH; i++) begin
        v_arr[i] <= '0;
        u_arr[i] <= '0;
      end
    end else begin
      state    <= state_nx;
      rst_done <= 1'b1;
      o_valid  <= 1'b0;

      if (int'(mon_sel) < NCH) begin
        mon_v <= v_arr[mon_sel[CHW-1:0]];
        mon_u <= u_arr[mon_sel[CHW-1:0]];
      end else begin
        mon_v <= '0;
        mon_u <= '0;
      end

      if (clear) begin
        ch      <= '0;
        spk_acc <= '0;
        o_spk   <= '0;
        spk_cnt <= '0;
        for (int i = 0; i < NCH; i++) begin
          v_arr[i] <= '0;
          u_arr[i] <= '0;
        end
      end else begin
        case (state)
          IDLE: if (s_valid && s_ready) begin
            x_q     <= s_data;
            ch      <= '0;
            spk_acc <= '0;
          end
          RUN: begin
            v_arr[ch] <= v_nx;
            u_arr[ch] <= u_nx;
            spk_acc   <= spk_new;
            ch        <= ch + 1'b1;
            // Publish on the last channel so o_spk is valid alongside o_valid in DONE.
            if (last_ch) begin
              o_spk   <= spk_new;
              o_valid <= 1'b1;
              spk_cnt <= cnt_nx;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ecg_spike_encoder_mc.sv
module tb_ecg_spike_encoder_mc;
  localparam int W   = 20;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam longint CMAX = (1 << CW) - 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                clear = 1'b0;
  logic signed [W-1:0] p = '0;
  logic signed [W-1:0] s_data = '0;
  logic                s_valid = 1'b0;
  logic                s_ready;
  logic [NCH-1:0]      o_spk;
  logic                o_any;
  logic                o_valid;
  logic [CW-1:0]       spk_cnt;
  logic [3:0]          mon_sel = '0;
  logic signed [W-1:0] mon_v;
  logic signed [W-1:0] mon_u;

  ecg_spike_encoder_mc #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .p(p), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready), .o_spk(o_spk), .o_any(o_any),
    .o_valid(o_valid), .spk_cnt(spk_cnt), .mon_sel(mon_sel),
    .mon_v(mon_v), .mon_u(mon_u)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int n_acc = 0;
  int n_out = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    else
      n_pass++;
  endtask

  // Reference model: per-channel V/U in plain integers with explicit clamping.
  longint mv [NCH];
  longint mu [NCH];
  longint mcnt = 0;

  typedef struct {
    logic [NCH-1:0] spk;
    longint         cnt;
    longint         acc_cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e_out;
  exp_t e_in;

  function automatic longint satm(input longint a);
    if (a > 524287)  return 524287;
    if (a < -524288) return -524288;
    return a;
  endfunction

  task automatic model_sample(input longint x, input longint pb, output logic [NCH-1:0] spk);
    longint ic, d, vn, un;
    int pop;
    pop = 0;
    spk = '0;
    for (int c = 0; c < NCH; c++) begin
      ic = (c % 2 == 1) ? (-x - 1) : x;
      ic = ic >>> (c / 2);
      d  = ic + pb - mu[c] - mv[c];
      vn = satm(mv[c] + (d >>> 2));
      un = satm(mu[c] + ((mv[c] - mu[c]) >>> 4));
      if (vn >= 65536) begin
        spk[c] = 1'b1;
        pop++;
        mv[c] = -65536;
        mu[c] = satm(un + 8192);
      end else begin
        mv[c] = vn;
        mu[c] = un;
      end
    end
    mcnt = mcnt + pop;
    if (mcnt > CMAX) mcnt = CMAX;
  endtask

  task automatic model_zero();
    for (int c = 0; c < NCH; c++) begin
      mv[c] = 0;
      mu[c] = 0;
    end
    mcnt = 0;
    sb.delete();
  endtask

  // Scoreboard: push on observed handshake, pop and compare on o_valid.
  always @(negedge clk) begin
    if (!reset) begin
      model_zero();
    end else begin
      if (o_valid) begin
        n_out++;
        if (sb.size() == 0) begin
          chk("unexpected_o_valid", 1, 0);
        end else begin
          e_out = sb.pop_front();
          chk("o_spk", longint'(o_spk), longint'(e_out.spk));
          chk("o_any", longint'(o_any), longint'(|e_out.spk));
          chk("spk_cnt", longint'(spk_cnt), e_out.cnt);
          chk("latency", cyc - e_out.acc_cyc, NCH + 1);
        end
      end
      if (clear) begin
        model_zero();
      end else if (s_valid && s_ready) begin
        n_acc++;
        model_sample(longint'(s_data), longint'(p), e_in.spk);
        e_in.cnt     = mcnt;
        e_in.acc_cyc = cyc;
        sb.push_back(e_in);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic send(input logic signed [W-1:0] x);
    wait_idle();
    s_data  = x;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    wait_idle();
  endtask

  task automatic mon_rd(input int c, output longint v, output longint u);
    mon_sel = 4'(c);
    tick();
    v = longint'(mon_v);
    u = longint'(mon_u);
  endtask

  task automatic check_state(input string tag);
    longint v, u;
    for (int c = 0; c < NCH; c++) begin
      mon_rd(c, v, u);
      chk({tag, "_v"}, v, mv[c]);
      chk({tag, "_u"}, u, mu[c]);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    longint v, u;
    int a0, o0;

    // Power-on reset values.
    repeat (3) tick();
    chk("rst_o_valid", longint'(o_valid), 0);
    chk("rst_o_spk", longint'(o_spk), 0);
    chk("rst_spk_cnt", longint'(spk_cnt), 0);
    chk("rst_s_ready", longint'(s_ready), 0);
    reset = 1'b1;
    tick();
    chk("rel_s_ready", longint'(s_ready), 1);
    chk("rst_mon_v", longint'(mon_v), 0);

    // Positive step on channel 0: sub-threshold then fire.
    p = '0;
    send(20'sh3_0000);
    mon_rd(0, v, u);
    chk("v0_after_3p0", v, 20'sh0_C000);
    check_state("s3a");
    send(20'sh3_0000);
    check_state("s3b");

    // Asynchronous reset in the middle of a sample.
    s_data  = 20'sh3_0000;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_o_spk", longint'(o_spk), 0);
    chk("mid_rst_o_any", longint'(o_any), 0);
    chk("mid_rst_spk_cnt", longint'(spk_cnt), 0);
    chk("mid_rst_mon_v", longint'(mon_v), 0);
    chk("mid_rst_mon_u", longint'(mon_u), 0);
    chk("mid_rst_s_ready", longint'(s_ready), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rel_s_ready", longint'(s_ready), 1);
    check_state("post_rst");

    // Negative step drives the inverted channel.
    send(20'shD_0000);
    mon_rd(1, v, u);
    chk("v1_after_m3p0", v, 20'sh0_BFFF);
    send(20'shD_0000);
    check_state("sm3");

    // Octave gain on channels 2/3, monitor range guard.
    pulse_clear();
    send(20'sh4_0000);
    mon_rd(2, v, u);
    chk("v2_after_4p0", v, 20'sh0_8000);
    check_state("s4");
    mon_rd(5, v, u);
    chk("mon5_v", v, 0);
    chk("mon5_u", u, 0);
    mon_rd(15, v, u);
    chk("mon15_v", v, 0);

    // s_valid held high: one accept per NCH+2 cycles.
    wait_idle();
    a0      = n_acc;
    s_data  = 20'sh2_0000;
    s_valid = 1'b1;
    repeat (3 * (NCH + 2)) tick();
    s_valid = 1'b0;
    chk("bp_accepts", n_acc - a0, 3);
    wait_idle();
    check_state("bp");

    // Clear while running: no o_valid, state zeroed, accept next cycle.
    wait_idle();
    o0      = n_out;
    s_data  = 20'sh3_0000;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    pulse_clear();
    chk("clr_s_ready", longint'(s_ready), 1);
    chk("clr_o_spk", longint'(o_spk), 0);
    chk("clr_spk_cnt", longint'(spk_cnt), 0);
    chk("clr_no_valid", n_out - o0, 0);
    a0      = n_acc;
    s_data  = 20'sh1_0000;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("clr_accept_next", n_acc - a0, 1);
    wait_idle();
    check_state("clr");

    // Full-scale negative drive: V/U saturate at the negative rail.
    pulse_clear();
    p = 20'sh8_0000;
    for (int k = 0; k < 6; k++) begin
      send(20'sh8_0000);
      check_state("negsat");
    end

    // Full-scale positive drive: counter saturates and holds.
    pulse_clear();
    p = 20'sh7_FFFF;
    for (int k = 0; k < 160; k++)
      send(20'sh7_FFFF);
    check_state("possat");
    chk("cnt_saturated", longint'(spk_cnt), CMAX);

    repeat (NCH + 4) tick();
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
